imem_loader: RTL and testbench

- Write-side counterpart of the instruction memory: receives a program as a big-endian byte stream, assembles 32-bit instruction words, and drives the memory write port starting at the text base address.
- Holds the CPU in reset (cpu_hold) while a load is in progress, so instruction fetch never sees a partially written program.
- Sits between the host/debug byte source and the instruction memory write port.

---
 rtl/imem_loader.sv | 137 +++++++++++++
 tb/tb_imem_loader.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a big-endian byte stream into 32-bit words,
// writes them from TEXT_BASE upward and holds the CPU in reset while loading.
module imem_loader #(
    parameter logic [31:0] TEXT_BASE = 32'h0000_3000,
    parameter int          DEPTH     = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [10:0] load_len,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        cpu_hold
);

    // Stream handshake: a byte moves on every rising edge where in_valid && in_ready;
    // in_valid may drop at any time, and in_ready is high only while receiving.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam logic [10:0] MAX_LEN = 11'(DEPTH);

    state_t      state;
    state_t      state_nx;
    logic [10:0] len_q;
    logic [10:0] word_idx;
    logic [1:0]  byte_cnt;
    logic [31:0] word_q;
    logic        len_ok;
    logic        accept;
    logic        start_ok;
    logic        start_bad;
    logic [31:0] word_nx;
    logic [31:0] addr_nx;

    assign len_ok    = (load_len != 11'd0) && (load_len <= MAX_LEN);
    assign accept    = in_valid && in_ready;
    assign start_ok  = (state == IDLE) && start && len_ok;
    assign start_bad = (state == IDLE) && start && !len_ok;
    assign word_nx   = {word_q[23:0], in_data};
    assign addr_nx   = TEXT_BASE + {19'd0, word_idx, 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nx = RECV;
                end
            end
            RECV: begin
                if (accept && (byte_cnt == 2'd3)) begin
                    state_nx = WRITE;
                end
            end
            WRITE: begin
                if ((word_idx + 11'd1) == len_q) begin
                    state_nx = FIN;
                end else begin
                    state_nx = RECV;
                end
            end
            FIN: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Datapath: length latch, word assembly and write index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q    <= 11'd0;
            word_idx <= 11'd0;
            byte_cnt <= 2'd0;
            word_q   <= 32'd0;
        end else begin
            if (start_ok) begin
                len_q    <= load_len;
                word_idx <= 11'd0;
                byte_cnt <= 2'd0;
                word_q   <= 32'd0;
            end else if (accept) begin
                word_q   <= word_nx;
                byte_cnt <= byte_cnt + 2'd1;
            end else if (state == WRITE) begin
                word_idx <= word_idx + 11'd1;
            end
        end
    end

    // Outputs are registered from the next state so each one lines up with its state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            cpu_hold  <= 1'b0;
        end else begin
            in_ready  <= (state_nx == RECV);
            mem_we    <= (state_nx == WRITE);
            mem_addr  <= (state_nx == WRITE) ? addr_nx : 32'd0;
            mem_wdata <= (state_nx == WRITE) ? word_nx : 32'd0;
            busy      <= (state_nx == RECV) || (state_nx == WRITE);
            cpu_hold  <= (state_nx == RECV) || (state_nx == WRITE);
            done      <= (state_nx == FIN);
            err       <= start_bad;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte driver, negedge write monitor and
// expected-write queues, with immediate assertions at each check point.
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [10:0] load_len;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic        cpu_hold;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] got_q[$];
    logic [31:0] got_addr_q[$];

    int cyc       = 0;
    int last_acc  = -10;
    int last_we   = -10;
    int done_cnt  = 0;
    int err_cnt   = 0;
    int hold_bad  = 0;
    int ready_bad = 0;
    int lat_bad   = 0;
    int gap_bad   = 0;

    imem_loader dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .load_len (load_len),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .cpu_hold (cpu_hold)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // monitor: collects writes and protocol counters away from the active edge
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) begin
            got_q.push_back(mem_wdata);
            got_addr_q.push_back(mem_addr);
            if (!cpu_hold || !busy) hold_bad <= hold_bad + 1;
            if (in_ready) ready_bad <= ready_bad + 1;
            if (cyc - last_acc != 1) lat_bad <= lat_bad + 1;
            last_we <= cyc;
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            if (cyc - last_we != 1) gap_bad <= gap_bad + 1;
            if (busy || cpu_hold) hold_bad <= hold_bad + 1;
        end
        if (err) err_cnt <= err_cnt + 1;
        if (in_valid && in_ready) last_acc <= cyc;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        n_tests++;
        n_fail++;
        $error("FAIL %s: timed out waiting for DUT", tag);
    endtask

    // driver tasks
    task automatic do_start(input logic [10:0] len);
        @(negedge clk);
        start    = 1'b1;
        load_len = len;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n;
        n = 0;
        if (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) timeout_fail("byte_accept");
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], gap);
    endtask

    task automatic wait_done(input int d0, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            n++;
        end while (done_cnt == d0 && n < 100);
        if (done_cnt == d0) timeout_fail(tag);
    endtask

    // scoreboard: compares collected writes against the expected queues
    task automatic check_writes(input string tag);
        int n;
        n = exp_q.size();
        check({tag, "_wcount"}, 32'(got_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (got_q.size() != 0) begin
                check({tag, "_data"}, got_q.pop_front(), exp_q.pop_front());
                check({tag, "_addr"}, got_addr_q.pop_front(), exp_addr_q.pop_front());
            end
        end
        exp_q.delete();
        exp_addr_q.delete();
        got_q.delete();
        got_addr_q.delete();
    endtask

    task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
        exp_addr_q.push_back(a);
        exp_q.push_back(d);
    endtask

    initial begin
        int d0;
        int e0;
        rst      = 1'b1;
        start    = 1'b0;
        load_len = 11'd0;
        in_valid = 1'b0;
        in_data  = 8'd0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_flags", {26'd0, in_ready, mem_we, busy, done, err, cpu_hold}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_flags", {26'd0, in_ready, mem_we, busy, done, err, cpu_hold}, 32'd0);

        // two-word load, in_valid always high
        d0 = done_cnt;
        do_start(11'd2);
        check("a_hold_after_start", {30'd0, cpu_hold, busy}, 32'd3);
        send_word(32'h3C08_0001, 1'b0);
        send_word(32'h2109_0004, 1'b0);
        wait_done(d0, "a_done_wait");
        check("a_done_flags", {29'd0, busy, cpu_hold, in_ready}, 32'd0);
        repeat (3) @(negedge clk);
        #1;
        check("a_done_count", 32'(done_cnt - d0), 32'd1);
        expect_write(32'h0000_3000, 32'h3C08_0001);
        expect_write(32'h0000_3004, 32'h2109_0004);
        check_writes("a");

        // same load with in_valid toggling
        d0 = done_cnt;
        do_start(11'd2);
        send_word(32'h3C08_0001, 1'b1);
        send_word(32'h2109_0004, 1'b1);
        wait_done(d0, "b_done_wait");
        repeat (3) @(negedge clk);
        #1;
        check("b_done_count", 32'(done_cnt - d0), 32'd1);
        expect_write(32'h0000_3000, 32'h3C08_0001);
        expect_write(32'h0000_3004, 32'h2109_0004);
        check_writes("b");

        // rejected starts
        e0 = err_cnt;
        do_start(11'd0);
        #1;
        check("len0_err", {29'd0, err, busy, cpu_hold}, 32'd4);
        @(negedge clk);
        #1;
        check("len0_err_pulse", {29'd0, err, busy, cpu_hold}, 32'd0);
        do_start(11'd1025);
        #1;
        check("len1025_err", {29'd0, err, busy, cpu_hold}, 32'd4);
        repeat (3) @(negedge clk);
        #1;
        check("rej_flags", {29'd0, busy, cpu_hold, mem_we}, 32'd0);
        check("rej_err_count", 32'(err_cnt - e0), 32'd2);
        check_writes("rej");

        // full-depth load, word k = k
        d0 = done_cnt;
        do_start(11'd1024);
        for (int k = 0; k < 1024; k++) begin
            send_word(32'(k), 1'b0);
            expect_write(32'h0000_3000 + 32'(4 * k), 32'(k));
        end
        wait_done(d0, "full_done_wait");
        repeat (10) @(negedge clk);
        #1;
        check("full_done_count", 32'(done_cnt - d0), 32'd1);
        if (got_q.size() != 0) begin
            check("full_last_addr", got_addr_q[got_addr_q.size() - 1], 32'h0000_3FFC);
            check("full_last_data", got_q[got_q.size() - 1], 32'h0000_03FF);
        end
        check_writes("full");

        // reset in the middle of word 3 of a four-word load
        do_start(11'd4);
        send_word(32'hA0A1_A2A3, 1'b0);
        send_word(32'hB0B1_B2B3, 1'b0);
        send_byte(8'hC0, 1'b0);
        send_byte(8'hC1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_flags", {26'd0, in_ready, mem_we, busy, done, err, cpu_hold}, 32'd0);
        check("mid_rst_addr", mem_addr, 32'd0);
        check("mid_rst_wdata", mem_wdata, 32'd0);
        expect_write(32'h0000_3000, 32'hA0A1_A2A3);
        expect_write(32'h0000_3004, 32'hB0B1_B2B3);
        check_writes("pre_rst");
        @(negedge clk);
        rst = 1'b0;
        d0 = done_cnt;
        do_start(11'd1);
        send_word(32'hDEAD_BEEF, 1'b0);
        wait_done(d0, "post_rst_done_wait");
        repeat (3) @(negedge clk);
        #1;
        expect_write(32'h0000_3000, 32'hDEAD_BEEF);
        check_writes("post_rst");

        // start while receiving is ignored
        d0 = done_cnt;
        e0 = err_cnt;
        do_start(11'd5);
        for (int i = 0; i < 20; i++) begin
            if (i == 6) begin
                start    = 1'b1;
                load_len = 11'd2;
            end
            if (i == 8) start = 1'b0;
            if (i == 12) begin
                start    = 1'b1;
                load_len = 11'd0;
            end
            if (i == 13) start = 1'b0;
            send_byte(8'(8'h40 + i), 1'b0);
        end
        wait_done(d0, "ign_done_wait");
        repeat (3) @(negedge clk);
        #1;
        check("ign_err_count", 32'(err_cnt - e0), 32'd0);
        check("ign_done_count", 32'(done_cnt - d0), 32'd1);
        expect_write(32'h0000_3000, 32'h4041_4243);
        expect_write(32'h0000_3004, 32'h4445_4647);
        expect_write(32'h0000_3008, 32'h4849_4A4B);
        expect_write(32'h0000_300C, 32'h4C4D_4E4F);
        expect_write(32'h0000_3010, 32'h5051_5253);
        check_writes("ign");

        // protocol counters accumulated by the monitor over the whole run
        check("hold_during_write", 32'(hold_bad), 32'd0);
        check("ready_low_in_write", 32'(ready_bad), 32'd0);
        check("byte_to_we_latency", 32'(lat_bad), 32'd0);
        check("we_to_done_latency", 32'(gap_bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
